axi_stream_master: RTL and testbench
====================================

# axi_stream_master

Self-contained AXI4-Stream video-style source: an internal pattern generator produces framed data beats, buffers them in a small FIFO and presents them on an AXI4-Stream master port with full tvalid/tready backpressure. It is the stimulus/source end of the filter pipeline and feeds any AXI4-Stream slave (e.g. the Wiener filter input). No beat is ever dropped or duplicated regardless of tready behaviour.

## Interface
- DATA_WIDTH, 32, width of tdata.
- LINE_LEN, 8, beats per line; tlast marks the final beat of each line (≥2).
- FRAME_LINES, 4, lines per frame; tuser marks the first beat of each frame (≥1).
- FIFO_DEPTH, 4, buffer entries (power of two, ≥2).
- INIT_VALUE, 0, first tdata value after reset.
- clk  in  1  single clock; all logic on its rising edge.
- rst_n  in  1  synchronous, active-high reset (1 = reset).
- m_axis_tdata  out  DATA_WIDTH  beat payload.
- m_axis_tvalid  out  1  beat available.
- m_axis_tready  in  1  slave accepts beat.
- m_axis_tlast  out  1  last beat of a line.
- m_axis_tuser  out  1  start of frame (first beat of frame).

## Operation
- Generator: holds data counter D, beat index B (0..LINE_LEN-1), line index L (0..FRAME_LINES-1). Produces one beat per cycle whenever FIFO can accept.
- Beat content: tdata=D, tlast=(B==LINE_LEN-1), tuser=(B==0 && L==0).
- After each generated beat: D += 1 modulo 2^DATA_WIDTH; B increments, wraps to 0 after LINE_LEN-1 and then L increments, wrapping to 0 after FRAME_LINES-1.
- FIFO write enable = not full OR read this cycle (write into full FIFO allowed when simultaneous pop).
- Output: first-word fall-through; m_axis_tvalid = FIFO not empty; tdata/tlast/tuser = head entry, driven 0 when tvalid=0.
- Transfer occurs on rising edge with tvalid=1 and tready=1; head popped.
- AXI rules: once tvalid=1, tvalid/tdata/tlast/tuser remain stable until accepted; tvalid never depends combinationally on tready.
- Generator runs continuously; no idle gaps inserted when FIFO has space.

## Timing
- Reset (rst_n=1 at a rising edge): FIFO emptied, D=INIT_VALUE, B=0, L=0; outputs tvalid=0, tdata=0, tlast=0, tuser=0 from that edge onward.
- First edge with reset released writes beat D=INIT_VALUE; tvalid=1 after that edge (1-cycle latency).
- FIFO fills to FIFO_DEPTH after FIFO_DEPTH released edges with tready=0; generator then stalls, D frozen.
- Sustained tready=1: one beat per cycle, no bubbles, including while full.
- tready deassert: head held; no beats lost; resume continues exact sequence.
- Reset mid-operation (incl. mid-line, FIFO full): all state discarded same edge; sequence restarts at INIT_VALUE with tuser=1.
- Wrap: D after 2^DATA_WIDTH-1 is 0; line/frame counters independent of D wrap.

## Configuration
- AXIS_MASTER_LFSR_EN defined: D advances as a maximal-length Galois LFSR (Fibonacci taps for DATA_WIDTH; INIT_VALUE of 0 replaced by 1) instead of +1. Framing (tlast/tuser) unchanged.
- Not defined: incrementing counter as above.

## Structure
- Shared package axis_master_pkg: default parameter constants, LFSR tap constant function, beat struct typedef (data, last, user) used as FIFO entry.
- One sub-module: axis_pattern_gen (D/B/L counters and beat formation, with ready input from FIFO). FIFO and output logic in top.

## Test plan
- Reset then tready=0 for 10 cycles -> tvalid=1 from first released edge, tdata=0 held, tuser=1, FIFO holds 0..3, generator stalled.
- Then tready=1 for 40 cycles -> tdata 0,1,2,...,39 one per cycle, no gaps; tlast on 7,15,23,31,39; tuser on 0 and 32 only.
- tready toggled 1/0 randomly for 200 cycles -> accepted sequence strictly consecutive, outputs stable while tvalid=1 and tready=0.
- Assert reset while FIFO full at D=21 -> next cycle all outputs 0; after release tdata restarts at 0 with tuser=1.
- DATA_WIDTH=4, LINE_LEN=4, FRAME_LINES=2, tready=1 -> tdata 0..15 then 0; tlast every 4th beat; tuser every 8th beat.
- AXIS_MASTER_LFSR_EN defined, DATA_WIDTH=8 -> 255 distinct nonzero values before repeat; framing identical to counter mode.

Source files
------------

// File: rtl/axis_master_pkg.sv
// Shared constants and types for the AXI4-Stream pattern source.
// Holds defaults, LFSR tap table and the beat framing tag.
package axis_master_pkg;

  localparam int AXIS_DATA_WIDTH  = 32;
  localparam int AXIS_LINE_LEN    = 8;
  localparam int AXIS_FRAME_LINES = 4;
  localparam int AXIS_FIFO_DEPTH  = 4;

  // Framing bits carried next to the payload of every beat.
  typedef struct packed {
    logic last;
    logic user;
  } beat_tag_t;

  // Galois right-shift feedback mask for a maximal-length LFSR.
  function automatic logic [63:0] lfsr_taps(input int width);
    logic [63:0] t;
    case (width)
      2:  t = 64'h3;
      3:  t = 64'h6;
      4:  t = 64'hC;
      5:  t = 64'h14;
      6:  t = 64'h30;
      7:  t = 64'h60;
      8:  t = 64'hB8;
      9:  t = 64'h110;
      10: t = 64'h240;
      11: t = 64'h500;
      12: t = 64'h829;
      13: t = 64'h100D;
      14: t = 64'h2015;
      15: t = 64'h6000;
      16: t = 64'hD008;
      17: t = 64'h12000;
      18: t = 64'h20400;
      19: t = 64'h40023;
      20: t = 64'h90000;
      21: t = 64'h140000;
      22: t = 64'h300000;
      23: t = 64'h420000;
      24: t = 64'hE10000;
      25: t = 64'h1200000;
      26: t = 64'h2000023;
      27: t = 64'h4000013;
      28: t = 64'h9000000;
      29: t = 64'h14000000;
      30: t = 64'h20000029;
      31: t = 64'h48000000;
      32: t = 64'h80200003;
      default: t = 64'h0;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/axis_pattern_gen.sv
// Framed beat generator: data counter plus beat/line position.
// AXIS_MASTER_LFSR_EN switches the data counter to a Galois LFSR.
module axis_pattern_gen
  import axis_master_pkg::*;
#(
  parameter int DATA_WIDTH  = AXIS_DATA_WIDTH,
  parameter int LINE_LEN    = AXIS_LINE_LEN,
  parameter int FRAME_LINES = AXIS_FRAME_LINES,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ready,
  output logic [DATA_WIDTH-1:0] data,
  output beat_tag_t             tag
);

  localparam int BW = (LINE_LEN > 1) ? $clog2(LINE_LEN) : 1;
  localparam int LW = (FRAME_LINES > 1) ? $clog2(FRAME_LINES) : 1;
  localparam logic [BW-1:0] B_LAST = BW'(LINE_LEN - 1);
  localparam logic [LW-1:0] L_LAST = LW'(FRAME_LINES - 1);

  logic [DATA_WIDTH-1:0] d;
  logic [DATA_WIDTH-1:0] d_next;
  logic [BW-1:0]         beat;
  logic [LW-1:0]         line;

`ifdef AXIS_MASTER_LFSR_EN
  localparam logic [63:0] TAPS_ALL = lfsr_taps(DATA_WIDTH);
  localparam logic [DATA_WIDTH-1:0] TAPS = TAPS_ALL[DATA_WIDTH-1:0];
  localparam logic [DATA_WIDTH-1:0] SEED =
    (INIT_VALUE == '0) ? DATA_WIDTH'(1) : INIT_VALUE;
  assign d_next = {1'b0, d[DATA_WIDTH-1:1]} ^ (d[0] ? TAPS : '0);
`else
  localparam logic [DATA_WIDTH-1:0] SEED = INIT_VALUE;
  assign d_next = d + DATA_WIDTH'(1);
`endif

  assign data     = d;
  assign tag.last = (beat == B_LAST);
  assign tag.user = (beat == '0) && (line == '0);

  // Advance data and position whenever the FIFO takes the beat.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      d    <= SEED;
      beat <= '0;
      line <= '0;
    end else if (ready) begin
      d <= d_next;
      if (beat == B_LAST) begin
        beat <= '0;
        line <= (line == L_LAST) ? '0 : line + LW'(1);
      end else begin
        beat <= beat + BW'(1);
      end
    end
  end

endmodule

// File: rtl/axi_stream_master.sv
// AXI4-Stream source: pattern generator feeding a fall-through FIFO.
// Build option AXIS_MASTER_LFSR_EN selects LFSR payload data.
module axi_stream_master
  import axis_master_pkg::*;
#(
  parameter int DATA_WIDTH  = AXIS_DATA_WIDTH,
  parameter int LINE_LEN    = AXIS_LINE_LEN,
  parameter int FRAME_LINES = AXIS_FRAME_LINES,
  parameter int FIFO_DEPTH  = AXIS_FIFO_DEPTH,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tuser
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    beat_tag_t             tag;
  } beat_t;

  beat_t       mem [FIFO_DEPTH];
  beat_t       gen_beat;
  beat_t       head;
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        empty;
  logic        full;
  logic        push;
  logic        pop;

  axis_pattern_gen #(
    .DATA_WIDTH (DATA_WIDTH),
    .LINE_LEN   (LINE_LEN),
    .FRAME_LINES(FRAME_LINES),
    .INIT_VALUE (INIT_VALUE)
  ) u_gen (
    .clk  (clk),
    .rst_n(rst_n),
    .ready(push),
    .data (gen_beat.data),
    .tag  (gen_beat.tag)
  );

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop   = !empty && m_axis_tready;
  assign push  = !full || pop;
  assign head  = mem[rd_ptr[AW-1:0]];

  assign m_axis_tvalid = !empty;
  assign m_axis_tdata  = empty ? '0 : head.data;
  assign m_axis_tlast  = !empty && head.tag.last;
  assign m_axis_tuser  = !empty && head.tag.user;

  // Storage needs no reset: contents are masked while empty.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= gen_beat;
  end

  // Pointer update; a pop frees the slot a same-cycle push uses.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

endmodule

// File: tb/tb_axi_stream_master.sv
// Self-checking bench for axi_stream_master (default and small config).
// Reference model tracks generated/accepted beat counts by index.
module tb_axi_stream_master;

  localparam int DW    = 32;
  localparam int LL    = 8;
  localparam int FL    = 4;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          tready = 1'b0;
  logic [DW-1:0] tdata;
  logic          tvalid, tlast, tuser;

  logic          rst2 = 1'b1;
  logic          tready2 = 1'b1;
  logic [3:0]    tdata2;
  logic          tvalid2, tlast2, tuser2;

  int total = 0;
  int bad   = 0;
  int n_acc = 0;
  int n_gen = 0;

  always #5 clk = ~clk;

  axi_stream_master #(
    .DATA_WIDTH(DW), .LINE_LEN(LL), .FRAME_LINES(FL),
    .FIFO_DEPTH(DEPTH), .INIT_VALUE('0)
  ) dut (
    .clk(clk), .rst_n(rst),
    .m_axis_tdata(tdata), .m_axis_tvalid(tvalid),
    .m_axis_tready(tready), .m_axis_tlast(tlast),
    .m_axis_tuser(tuser)
  );

  axi_stream_master #(
    .DATA_WIDTH(4), .LINE_LEN(4), .FRAME_LINES(2),
    .FIFO_DEPTH(4), .INIT_VALUE('0)
  ) dut2 (
    .clk(clk), .rst_n(rst2),
    .m_axis_tdata(tdata2), .m_axis_tvalid(tvalid2),
    .m_axis_tready(tready2), .m_axis_tlast(tlast2),
    .m_axis_tuser(tuser2)
  );

  typedef struct {
    bit          rdy;
    bit          valid;
    logic [31:0] data;
    bit          last;
    bit          user;
  } vec_t;

  vec_t tbl [50];

  // Payload of beat number idx for a w-bit source starting at zero.
  function automatic logic [63:0] beat_val(int idx, int w);
    logic [63:0] m;
    logic [63:0] d;
    m = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
`ifdef AXIS_MASTER_LFSR_EN
    d = 64'd1;
    for (int k = 0; k < idx; k++) begin
      d = (d >> 1) ^ (d[0] ? axis_master_pkg::lfsr_taps(w) : 64'd0);
      d = d & m;
    end
`else
    d = 64'(idx) & m;
`endif
    return d;
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Compare outputs against the beat the model says is at the head.
  task automatic check_outputs(string tag);
    bit ev;
    ev = (n_gen > n_acc);
    chk({tag, "_valid"}, 64'(tvalid), 64'(ev));
    if (ev) begin
      chk({tag, "_data"}, 64'(tdata), beat_val(n_acc, DW));
      chk({tag, "_last"}, 64'(tlast), 64'((n_acc % LL) == LL - 1));
      chk({tag, "_user"}, 64'(tuser), 64'((n_acc % (LL*FL)) == 0));
    end else begin
      chk({tag, "_data0"}, 64'(tdata), 64'd0);
      chk({tag, "_last0"}, 64'(tlast), 64'd0);
      chk({tag, "_user0"}, 64'(tuser), 64'd0);
    end
  endtask

  // One clock: advance the beat-count model at the edge.
  task automatic tick();
    bit v, pop, push;
    @(posedge clk);
    if (rst) begin
      n_acc = 0;
      n_gen = 0;
    end else begin
      v    = (n_gen > n_acc);
      pop  = v && tready;
      push = ((n_gen - n_acc) < DEPTH) || pop;
      if (pop)  n_acc++;
      if (push) n_gen++;
    end
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 50; i++) begin
      if (i < 10) begin
        tbl[i] = '{1'b0, 1'b1, beat_val(0, DW), 1'b0, 1'b1};
      end else begin
        int k;
        k = i - 10;
        tbl[i] = '{1'b1, 1'b1, beat_val(k, DW),
                   (k % LL) == LL - 1, (k % (LL*FL)) == 0};
      end
    end

    @(negedge clk);
    tick();
    check_outputs("reset");
    rst = 1'b0;
    tick();

    for (int i = 0; i < 50; i++) begin
      tready = tbl[i].rdy;
      chk("tbl_valid", 64'(tvalid), 64'(tbl[i].valid));
      chk("tbl_data", 64'(tdata), 64'(tbl[i].data));
      chk("tbl_last", 64'(tlast), 64'(tbl[i].last));
      chk("tbl_user", 64'(tuser), 64'(tbl[i].user));
      tick();
    end
    chk("after_tbl_acc", 64'(n_acc), 64'd40);

    for (int i = 0; i < 200; i++) begin
      tready = 1'($urandom_range(0, 1));
      check_outputs("rand");
      tick();
    end

    rst = 1'b1;
    tready = 1'b0;
    tick();
    check_outputs("rst1");
    rst = 1'b0;
    tready = 1'b1;
    tick();
    for (int i = 0; i < 100; i++) begin
      if (n_acc == 17) break;
      check_outputs("seek");
      tick();
    end
    chk("seek_d17", 64'(n_acc), 64'd17);
    tready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      check_outputs("fill");
      tick();
    end
    chk("full_gen", 64'(n_gen), 64'd21);
    rst = 1'b1;
    tick();
    chk("midrst_valid", 64'(tvalid), 64'd0);
    chk("midrst_data", 64'(tdata), 64'd0);
    chk("midrst_last", 64'(tlast), 64'd0);
    chk("midrst_user", 64'(tuser), 64'd0);
    rst = 1'b0;
    tready = 1'b1;
    tick();
    chk("restart_valid", 64'(tvalid), 64'd1);
    chk("restart_data", 64'(tdata), beat_val(0, DW));
    chk("restart_user", 64'(tuser), 64'd1);
    for (int i = 0; i < 12; i++) begin
      tready = 1'($urandom_range(0, 1));
      check_outputs("post");
      tick();
    end

    rst2 = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 20; i++) begin
      chk("s_valid", 64'(tvalid2), 64'd1);
      chk("s_data", 64'(tdata2), beat_val(i, 4));
      chk("s_last", 64'(tlast2), 64'((i % 4) == 3));
      chk("s_user", 64'(tuser2), 64'((i % 8) == 0));
      @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
